// File: rtl/ysyx_22050078_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard / sequencing controller.
//   pctrl_state_e : sequencing FSM states (RUN, MEMWAIT)
//   pctrl_ctl_t   : bundle of pipe-register control strobes
//   CTL_*         : the five fixed control patterns the controller can emit
//   pctrl_decode  : priority selection of a control pattern
// ---------------------------------------------------------------------------
package ysyx_22050078_pipe_ctrl_pkg;

   localparam int PCTRL_CNT_W     = 32;
   localparam int PCTRL_REG_ADDRW = 5;

   typedef enum logic [0:0] {
      PCTRL_RUN     = 1'b0,
      PCTRL_MEMWAIT = 1'b1
   } pctrl_state_e;

   typedef struct packed {
      logic pc_wen;
      logic if_id_wen;
      logic if_id_flush;
      logic id_ex_wen;
      logic id_ex_bubble;
      logic ex_ls_wen;
      logic ls_wb_bubble;
   } pctrl_ctl_t;

   // Held in reset: nothing advances, every stage is refilled with bubbles.
   localparam pctrl_ctl_t CTL_RESET = '{
      pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b1, id_ex_wen: 1'b0,
      id_ex_bubble: 1'b1, ex_ls_wen: 1'b0, ls_wb_bubble: 1'b1};

   // Memory wait: freeze the whole front of the pipe, drain a bubble into WB.
   localparam pctrl_ctl_t CTL_MEMSTALL = '{
      pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b0, id_ex_wen: 1'b0,
      id_ex_bubble: 1'b0, ex_ls_wen: 1'b0, ls_wb_bubble: 1'b1};

   // Redirect: everything advances, the two younger wrong-path slots die.
   localparam pctrl_ctl_t CTL_REDIRECT = '{
      pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b1, id_ex_wen: 1'b1,
      id_ex_bubble: 1'b1, ex_ls_wen: 1'b1, ls_wb_bubble: 1'b0};

   // Load-use: hold PC and IF/ID, insert one bubble behind the load.
   localparam pctrl_ctl_t CTL_LDUSE = '{
      pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b0, id_ex_wen: 1'b1,
      id_ex_bubble: 1'b1, ex_ls_wen: 1'b1, ls_wb_bubble: 1'b0};

   // Free-running pipeline.
   localparam pctrl_ctl_t CTL_RUN = '{
      pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b0, id_ex_wen: 1'b1,
      id_ex_bubble: 1'b0, ex_ls_wen: 1'b1, ls_wb_bubble: 1'b0};

   // A memory stall freezes EX, so any redirect or load-use seen there is
   // simply re-presented once the wait ends; a redirect squashes the ID
   // instruction, so its load-use condition is irrelevant.
   function automatic pctrl_ctl_t pctrl_decode(
      input logic rst,
      input logic mem_stall,
      input logic redirect,
      input logic ld_use
   );
      pctrl_ctl_t ctl;
      if (rst) begin
         ctl = CTL_RESET;
      end else if (mem_stall) begin
         ctl = CTL_MEMSTALL;
      end else if (redirect) begin
         ctl = CTL_REDIRECT;
      end else if (ld_use) begin
         ctl = CTL_LDUSE;
      end else begin
         ctl = CTL_RUN;
      end
      return ctl;
   endfunction

endpackage

// File: rtl/ysyx_22050078_sat_cnt.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_sat_cnt
// Saturating event counter: counts cycles with i_inc high, sticks at all-ones.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset, clears the count
//   i_inc  : count this cycle
//   o_cnt  : current count (registered)
// ---------------------------------------------------------------------------
module ysyx_22050078_sat_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // Next count: increment unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (i_inc && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= {WIDTH{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/ysyx_22050078_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_pipe_ctrl
// Hazard and sequencing controller for the 5-stage pipeline. Produces the
// write-enables / bubbles / flushes of the PC, IF/ID, ID/EX, EX/LS and LS/WB
// registers from load-use hazards, EX redirects and LS memory waits.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_id_rs1/rs2_addr, _ren   : sources read by the instruction in ID
//   i_id_ldstbp               : ID store whose rs2 can come from the LS bypass
//   i_ex_rd_addr, i_ex_lden   : destination of EX instruction, EX is a load
//   i_ex_redirect             : taken branch/jump resolved in EX
//   i_ls_req, i_ls_ready      : LS memory access pending / completing
//   o_pc_wen .. o_ls_wb_bubble: pipe-register controls (combinational)
//   o_stall_cnt, o_flush_cnt  : saturating stall / flush cycle counters
//   o_mem_timeout             : sticky flag, one memory wait ran TIMEOUT cycles
// ---------------------------------------------------------------------------
module ysyx_22050078_pipe_ctrl
   import ysyx_22050078_pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDRW = PCTRL_REG_ADDRW,
   parameter int CNT_W     = PCTRL_CNT_W,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [REG_ADDRW-1:0] i_id_rs1_addr,
   input  logic [REG_ADDRW-1:0] i_id_rs2_addr,
   input  logic                 i_id_rs1_ren,
   input  logic                 i_id_rs2_ren,
   input  logic                 i_id_ldstbp,
   input  logic [REG_ADDRW-1:0] i_ex_rd_addr,
   input  logic                 i_ex_lden,
   input  logic                 i_ex_redirect,
   input  logic                 i_ls_req,
   input  logic                 i_ls_ready,
   output logic                 o_pc_wen,
   output logic                 o_if_id_wen,
   output logic                 o_if_id_flush,
   output logic                 o_id_ex_wen,
   output logic                 o_id_ex_bubble,
   output logic                 o_ex_ls_wen,
   output logic                 o_ls_wb_bubble,
   output logic [CNT_W-1:0]     o_stall_cnt,
   output logic [CNT_W-1:0]     o_flush_cnt,
   output logic                 o_mem_timeout
);

   // wait_cnt only ever needs to reach TIMEOUT-1, where it parks.
   localparam int                WAIT_W    = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   pctrl_state_e      state_d;
   pctrl_state_e      state_q;
   logic [WAIT_W-1:0] wait_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              timeout_d;
   logic              timeout_q;

   logic              rs1_hit_s;
   logic              rs2_hit_s;
   logic              ld_use_s;
   logic              mem_stall_s;
   pctrl_ctl_t        ctl_s;
   logic              stall_inc_s;
   logic              flush_inc_s;

   // Load-use detection; x0 never creates a dependency, and a store whose rs2
   // is served by the load-store bypass need not wait for the load.
   always_comb begin
      rs1_hit_s = i_id_rs1_ren & (i_id_rs1_addr == i_ex_rd_addr);
      rs2_hit_s = i_id_rs2_ren & (i_id_rs2_addr == i_ex_rd_addr) & ~i_id_ldstbp;
      ld_use_s  = i_ex_lden & (i_ex_rd_addr != {REG_ADDRW{1'b0}})
                  & (rs1_hit_s | rs2_hit_s);
   end

   // Memory stall: in RUN only a fresh request can stall; once in MEMWAIT the
   // request is already latched in LS, so only readiness matters.
   always_comb begin
      mem_stall_s = 1'b0;
      case (state_q)
         PCTRL_RUN:     mem_stall_s = i_ls_req & ~i_ls_ready;
         PCTRL_MEMWAIT: mem_stall_s = ~i_ls_ready;
         default:       mem_stall_s = 1'b0;
      endcase
   end

   assign ctl_s = pctrl_decode(i_rst, mem_stall_s, i_ex_redirect, ld_use_s);

   assign o_pc_wen       = ctl_s.pc_wen;
   assign o_if_id_wen    = ctl_s.if_id_wen;
   assign o_if_id_flush  = ctl_s.if_id_flush;
   assign o_id_ex_wen    = ctl_s.id_ex_wen;
   assign o_id_ex_bubble = ctl_s.id_ex_bubble;
   assign o_ex_ls_wen    = ctl_s.ex_ls_wen;
   assign o_ls_wb_bubble = ctl_s.ls_wb_bubble;

   // FSM next state, wait counter and sticky timeout.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         PCTRL_RUN: begin
            if (i_ls_req && !i_ls_ready) begin
               state_d    = PCTRL_MEMWAIT;
               wait_cnt_d = {WAIT_W{1'b0}};
            end else begin
               state_d    = PCTRL_RUN;
               wait_cnt_d = wait_cnt_q;
            end
         end
         PCTRL_MEMWAIT: begin
            if (i_ls_ready) begin
               state_d = PCTRL_RUN;
            end else begin
               state_d = PCTRL_MEMWAIT;
            end
            // The TIMEOUT-th consecutive waiting cycle trips the flag.
            if (!i_ls_ready && (wait_cnt_q == WAIT_LAST)) begin
               timeout_d = 1'b1;
            end else begin
               timeout_d = timeout_q;
            end
            if (wait_cnt_q != WAIT_LAST) begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
               wait_cnt_d = wait_cnt_q;
            end
         end
         default: begin
            state_d    = PCTRL_RUN;
            wait_cnt_d = {WAIT_W{1'b0}};
            timeout_d  = timeout_q;
         end
      endcase
   end

   // FSM state registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= PCTRL_RUN;
         wait_cnt_q <= {WAIT_W{1'b0}};
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_mem_timeout = timeout_q;

   // Reset cycles are excluded from both statistics.
   assign stall_inc_s = ~ctl_s.pc_wen & ~i_rst;
   assign flush_inc_s = ctl_s.if_id_flush & ~i_rst;

   ysyx_22050078_sat_cnt #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (stall_inc_s),
      .o_cnt (o_stall_cnt)
   );

   ysyx_22050078_sat_cnt #(
      .WIDTH (CNT_W)
   ) u_flush_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (flush_inc_s),
      .o_cnt (o_flush_cnt)
   );

endmodule

// File: tb/tb_ysyx_22050078_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050078_pipe_ctrl
// Directed bench. Two instances share one stimulus: dut_a (CNT_W=32,
// TIMEOUT=4) and dut_b (CNT_W=2) for counter saturation.
// Control bits are packed as
//   {pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_bubble, ex_ls_wen, ls_wb_bubble}
// ---------------------------------------------------------------------------
module tb_ysyx_22050078_pipe_ctrl;

   localparam logic [6:0] EXP_RESET    = 7'b0010101;
   localparam logic [6:0] EXP_MEMSTALL = 7'b0000001;
   localparam logic [6:0] EXP_REDIRECT = 7'b1111110;
   localparam logic [6:0] EXP_LDUSE    = 7'b0001110;
   localparam logic [6:0] EXP_RUN      = 7'b1101010;

   logic       clk;
   logic       rst;
   logic [4:0] rs1_addr;
   logic [4:0] rs2_addr;
   logic       rs1_ren;
   logic       rs2_ren;
   logic       ldstbp;
   logic [4:0] rd_addr;
   logic       lden;
   logic       redirect;
   logic       ls_req;
   logic       ls_ready;

   logic        a_pc_wen, a_if_id_wen, a_if_id_flush, a_id_ex_wen;
   logic        a_id_ex_bubble, a_ex_ls_wen, a_ls_wb_bubble, a_timeout;
   logic [31:0] a_stall_cnt, a_flush_cnt;
   logic        b_pc_wen, b_if_id_wen, b_if_id_flush, b_id_ex_wen;
   logic        b_id_ex_bubble, b_ex_ls_wen, b_ls_wb_bubble, b_timeout;
   logic [1:0]  b_stall_cnt, b_flush_cnt;
   logic [6:0]  ctl_a;
   logic [6:0]  ctl_b;

   int checks   = 0;
   int failures = 0;

   assign ctl_a = {a_pc_wen, a_if_id_wen, a_if_id_flush, a_id_ex_wen,
                   a_id_ex_bubble, a_ex_ls_wen, a_ls_wb_bubble};
   assign ctl_b = {b_pc_wen, b_if_id_wen, b_if_id_flush, b_id_ex_wen,
                   b_id_ex_bubble, b_ex_ls_wen, b_ls_wb_bubble};

   ysyx_22050078_pipe_ctrl #(.REG_ADDRW(5), .CNT_W(32), .TIMEOUT(4)) dut_a (
      .i_clk (clk), .i_rst (rst),
      .i_id_rs1_addr (rs1_addr), .i_id_rs2_addr (rs2_addr),
      .i_id_rs1_ren (rs1_ren), .i_id_rs2_ren (rs2_ren),
      .i_id_ldstbp (ldstbp), .i_ex_rd_addr (rd_addr),
      .i_ex_lden (lden), .i_ex_redirect (redirect),
      .i_ls_req (ls_req), .i_ls_ready (ls_ready),
      .o_pc_wen (a_pc_wen), .o_if_id_wen (a_if_id_wen),
      .o_if_id_flush (a_if_id_flush), .o_id_ex_wen (a_id_ex_wen),
      .o_id_ex_bubble (a_id_ex_bubble), .o_ex_ls_wen (a_ex_ls_wen),
      .o_ls_wb_bubble (a_ls_wb_bubble), .o_stall_cnt (a_stall_cnt),
      .o_flush_cnt (a_flush_cnt), .o_mem_timeout (a_timeout)
   );

   ysyx_22050078_pipe_ctrl #(.REG_ADDRW(5), .CNT_W(2), .TIMEOUT(1024)) dut_b (
      .i_clk (clk), .i_rst (rst),
      .i_id_rs1_addr (rs1_addr), .i_id_rs2_addr (rs2_addr),
      .i_id_rs1_ren (rs1_ren), .i_id_rs2_ren (rs2_ren),
      .i_id_ldstbp (ldstbp), .i_ex_rd_addr (rd_addr),
      .i_ex_lden (lden), .i_ex_redirect (redirect),
      .i_ls_req (ls_req), .i_ls_ready (ls_ready),
      .o_pc_wen (b_pc_wen), .o_if_id_wen (b_if_id_wen),
      .o_if_id_flush (b_if_id_flush), .o_id_ex_wen (b_id_ex_wen),
      .o_id_ex_bubble (b_id_ex_bubble), .o_ex_ls_wen (b_ex_ls_wen),
      .o_ls_wb_bubble (b_ls_wb_bubble), .o_stall_cnt (b_stall_cnt),
      .o_flush_cnt (b_flush_cnt), .o_mem_timeout (b_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_ren = 1'b0; rs2_ren = 1'b0;
      ldstbp = 1'b0; rd_addr = 5'd0; lden = 1'b0; redirect = 1'b0;
      ls_req = 1'b0; ls_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clr_in();
      tick();
      tick();
      #2;
      // Reset state and forced outputs.
      chk("rst_ctl_a", {25'd0, ctl_a}, {25'd0, EXP_RESET});
      chk("rst_ctl_b", {25'd0, ctl_b}, {25'd0, EXP_RESET});
      chk("rst_stall", a_stall_cnt, 32'd0);
      chk("rst_flush", a_flush_cnt, 32'd0);
      chk("rst_tmo", {31'd0, a_timeout}, 32'd0);
      rst = 1'b0;
      #2;
      chk("idle_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      tick();
      chk("idle_stall", a_stall_cnt, 32'd0);

      // Load-use on rs1: one bubble cycle, then free running.
      lden = 1'b1; rd_addr = 5'd5; rs1_addr = 5'd5; rs1_ren = 1'b1;
      #2;
      chk("lduse_ctl", {25'd0, ctl_a}, {25'd0, EXP_LDUSE});
      tick();
      lden = 1'b0;
      #2;
      chk("lduse_after_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      chk("lduse_stall", a_stall_cnt, 32'd1);
      chk("lduse_flush", a_flush_cnt, 32'd0);

      // rs2 with load-store bypass: no stall; without bypass: stall.
      clr_in();
      lden = 1'b1; rd_addr = 5'd5; rs2_addr = 5'd5; rs2_ren = 1'b1; ldstbp = 1'b1;
      #2;
      chk("bypass_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      ldstbp = 1'b0;
      #2;
      chk("rs2_lduse_ctl", {25'd0, ctl_a}, {25'd0, EXP_LDUSE});
      // rs1 not read: no hazard even if addresses match.
      clr_in();
      lden = 1'b1; rd_addr = 5'd7; rs1_addr = 5'd7; rs1_ren = 1'b0;
      #2;
      chk("noren_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      // x0 destination never stalls.
      clr_in();
      lden = 1'b1; rd_addr = 5'd0; rs1_addr = 5'd0; rs1_ren = 1'b1;
      #2;
      chk("x0_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      tick();
      chk("x0_stall", a_stall_cnt, 32'd1);

      // Redirect plus load-use in the same cycle.
      clr_in();
      do_reset();
      redirect = 1'b1; lden = 1'b1; rd_addr = 5'd5; rs1_addr = 5'd5; rs1_ren = 1'b1;
      #2;
      chk("redir_ctl", {25'd0, ctl_a}, {25'd0, EXP_REDIRECT});
      tick();
      clr_in();
      #2;
      chk("redir_flush", a_flush_cnt, 32'd1);
      chk("redir_stall", a_stall_cnt, 32'd0);

      // Memory wait, 3 waiting cycles then ready. Request drops in MEMWAIT.
      ls_req = 1'b1; ls_ready = 1'b0;
      #2;
      chk("mw1_ctl", {25'd0, ctl_a}, {25'd0, EXP_MEMSTALL});
      tick();
      ls_req = 1'b0;
      #2;
      chk("mw2_ctl", {25'd0, ctl_a}, {25'd0, EXP_MEMSTALL});
      tick();
      #2;
      chk("mw3_ctl", {25'd0, ctl_a}, {25'd0, EXP_MEMSTALL});
      tick();
      ls_ready = 1'b1;
      #2;
      chk("mw_ready_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      tick();
      ls_ready = 1'b0;
      #2;
      chk("mw_back_run", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      chk("mw_stall", a_stall_cnt, 32'd3);

      // Same wait with redirect held: flush only on the ready cycle.
      redirect = 1'b1; ls_req = 1'b1; ls_ready = 1'b0;
      tick();
      tick();
      #2;
      chk("mwr3_ctl", {25'd0, ctl_a}, {25'd0, EXP_MEMSTALL});
      tick();
      ls_ready = 1'b1;
      #2;
      chk("mwr_ready_ctl", {25'd0, ctl_a}, {25'd0, EXP_REDIRECT});
      tick();
      clr_in();
      #2;
      chk("mwr_flush", a_flush_cnt, 32'd2);
      chk("mwr_stall", a_stall_cnt, 32'd6);

      // Request and ready in the same RUN cycle: no stall, stays in RUN.
      ls_req = 1'b1; ls_ready = 1'b1;
      #2;
      chk("hit_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      tick();
      ls_req = 1'b0; ls_ready = 1'b0;
      #2;
      chk("hit_state_run", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      chk("hit_stall", a_stall_cnt, 32'd6);

      // Timeout with TIMEOUT=4 on dut_a.
      ls_req = 1'b1; ls_ready = 1'b0;
      tick();
      ls_req = 1'b0;
      tick();
      tick();
      #2;
      chk("tmo_wc2", {31'd0, a_timeout}, 32'd0);
      tick();
      #2;
      chk("tmo_wc3", {31'd0, a_timeout}, 32'd0);
      tick();
      #2;
      chk("tmo_set", {31'd0, a_timeout}, 32'd1);
      ls_ready = 1'b1;
      tick();
      ls_ready = 1'b0;
      #2;
      chk("tmo_sticky", {31'd0, a_timeout}, 32'd1);
      chk("tmo_run_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});

      // Reset in the middle of a memory wait.
      ls_req = 1'b1; ls_ready = 1'b0;
      tick();
      ls_req = 1'b0;
      tick();
      rst = 1'b1;
      #2;
      chk("mrst_ctl", {25'd0, ctl_a}, {25'd0, EXP_RESET});
      tick();
      rst = 1'b0;
      #2;
      chk("mrst_run_ctl", {25'd0, ctl_a}, {25'd0, EXP_RUN});
      chk("mrst_stall", a_stall_cnt, 32'd0);
      chk("mrst_flush", a_flush_cnt, 32'd0);
      chk("mrst_tmo", {31'd0, a_timeout}, 32'd0);
      chk("mrst_b_stall", 32'(b_stall_cnt), 32'd0);

      // Saturation: 5 stall cycles then 5 flush cycles.
      ls_req = 1'b1; ls_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      #2;
      chk("sat_a_stall", a_stall_cnt, 32'd5);
      chk("sat_b_stall", 32'(b_stall_cnt), 32'd3);
      ls_req = 1'b0; ls_ready = 1'b1; redirect = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      #2;
      chk("sat_a_flush", a_flush_cnt, 32'd5);
      chk("sat_b_flush", 32'(b_flush_cnt), 32'd3);
      chk("sat_b_stall_hold", 32'(b_stall_cnt), 32'd3);
      clr_in();
      do_reset();
      #2;
      chk("sat_b_clr", 32'(b_flush_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
